// File: rtl/tomasulo_exec_units.sv
// Tomasulo execution back end: an add/sub unit, a mul/div unit and the
// combinational CDB select mux. Each unit latches its operands on an
// accepted Run, counts down a fixed op latency, then holds its result and
// label with Done high until the controller drops Run.
//
// Handshake: Run is a level request. IDLE with Run=1 accepts on that edge.
// Dropping Run while BUSY aborts the op. In DONE, Done stays high while Run
// stays high; the first edge with Run=0 clears Done and returns to IDLE.
// The next op can be accepted no earlier than the following edge.

module tomasulo_fu #(
  parameter int WIDTH     = 12,
  parameter int LABEL_W   = 2,
  parameter int LAT_OP0   = 2,  // latency when Op[0]=0 (ADD or MUL)
  parameter int LAT_OP1   = 2,  // latency when Op[0]=1 (SUB or DIV)
  parameter bit IS_MULDIV = 1'b0
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_run,
  input  logic [WIDTH-1:0]   i_rx,
  input  logic [WIDTH-1:0]   i_ry,
  input  logic               i_op_sel,
  input  logic [LABEL_W-1:0] i_label,
  output logic [WIDTH-1:0]   o_result,
  output logic               o_done,
  output logic [LABEL_W-1:0] o_label,
  output logic [1:0]         o_state
);

  localparam int MAX_LAT = (LAT_OP0 > LAT_OP1) ? LAT_OP0 : LAT_OP1;
  localparam int CNT_W   = $clog2(MAX_LAT + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nx;
  logic               w_load;
  logic               w_finish;
  logic [CNT_W-1:0]   r_cnt;
  logic [WIDTH-1:0]   r_rx;
  logic [WIDTH-1:0]   r_ry;
  logic               r_op;
  logic [LABEL_W-1:0] r_label;
  logic [WIDTH-1:0]   r_result;
  logic [LABEL_W-1:0] r_label_out;
  logic [WIDTH-1:0]   w_result;

  // State register
  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_state_nx;
  end

  // Next state: accept in IDLE, abort or complete in BUSY, release in DONE
  always_comb begin
    w_state_nx = r_state;
    w_load     = 1'b0;
    w_finish   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_run) begin
          w_state_nx = S_BUSY;
          w_load     = 1'b1;
        end
      end
      S_BUSY: begin
        if (!i_run) begin
          w_state_nx = S_IDLE;
        end else if (r_cnt == '0) begin
          w_state_nx = S_DONE;
          w_finish   = 1'b1;
        end
      end
      S_DONE: begin
        if (!i_run) w_state_nx = S_IDLE;
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

  // Datapath from latched operands only, so input changes while BUSY are ignored
  generate
    if (IS_MULDIV) begin : g_muldiv
      always_comb begin
        w_result = '0;
        if (!r_op)            w_result = r_rx * r_ry;
        else if (r_ry == '0)  w_result = '1;
        else                  w_result = r_rx / r_ry;
      end
    end else begin : g_addsub
      always_comb begin
        w_result = '0;
        if (r_op) w_result = r_rx - r_ry;
        else      w_result = r_rx + r_ry;
      end
    end
  endgenerate

  // Operand latch, latency counter and result/label registers.
  // Counter loads LAT-1 so Done rises exactly LAT edges after the accept.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt       <= '0;
      r_rx        <= '0;
      r_ry        <= '0;
      r_op        <= 1'b0;
      r_label     <= '0;
      r_result    <= '0;
      r_label_out <= '0;
    end else begin
      if (w_load) begin
        r_rx    <= i_rx;
        r_ry    <= i_ry;
        r_op    <= i_op_sel;
        r_label <= i_label;
        r_cnt   <= i_op_sel ? CNT_W'(LAT_OP1 - 1) : CNT_W'(LAT_OP0 - 1);
      end else if (r_state == S_BUSY && r_cnt != '0) begin
        r_cnt <= r_cnt - 1'b1;
      end
      if (w_finish) begin
        r_result    <= w_result;
        r_label_out <= r_label;
      end
    end
  end

  assign o_result = r_result;
  assign o_label  = r_label_out;
  assign o_done   = (r_state == S_DONE);
  assign o_state  = r_state;

endmodule

module tomasulo_exec_units #(
  parameter int WIDTH      = 12,
  parameter int LABEL_W    = 2,
  parameter int ADDSUB_LAT = 2,
  parameter int MUL_LAT    = 4,
  parameter int DIV_LAT    = 6
) (
  input  logic               Clock,
  input  logic               Reset,
  input  logic               Run_AddSub,
  input  logic [WIDTH-1:0]   Rx_AddSub,
  input  logic [WIDTH-1:0]   Ry_AddSub,
  input  logic [2:0]         Op_AddSub,
  input  logic [LABEL_W-1:0] Label_AddSub,
  output logic [WIDTH-1:0]   Result_AddSub,
  output logic               Done_AddSub,
  output logic [LABEL_W-1:0] Label_AddSub_out,
  input  logic               Run_MulDiv,
  input  logic [WIDTH-1:0]   Rx_MulDiv,
  input  logic [WIDTH-1:0]   Ry_MulDiv,
  input  logic [2:0]         Op_MulDiv,
  input  logic [LABEL_W-1:0] Label_MulDiv,
  output logic [WIDTH-1:0]   Result_MulDiv,
  output logic               Done_MulDiv,
  output logic [LABEL_W-1:0] Label_MulDiv_out,
  input  logic [1:0]         CDB_Control,
  output logic [WIDTH-1:0]   CDB,
  output logic [1:0]         Dbg_State_AddSub,
  output logic [1:0]         Dbg_State_MulDiv
);

  // Only Op[0] selects the operation; the upper opcode bits are don't-care
  logic w_unused_op;
  assign w_unused_op = ^{Op_AddSub[2:1], Op_MulDiv[2:1]};

  tomasulo_fu #(
    .WIDTH(WIDTH), .LABEL_W(LABEL_W),
    .LAT_OP0(ADDSUB_LAT), .LAT_OP1(ADDSUB_LAT), .IS_MULDIV(1'b0)
  ) u_addsub (
    .i_clk(Clock), .i_rst(Reset), .i_run(Run_AddSub),
    .i_rx(Rx_AddSub), .i_ry(Ry_AddSub), .i_op_sel(Op_AddSub[0]),
    .i_label(Label_AddSub), .o_result(Result_AddSub), .o_done(Done_AddSub),
    .o_label(Label_AddSub_out), .o_state(Dbg_State_AddSub)
  );

  tomasulo_fu #(
    .WIDTH(WIDTH), .LABEL_W(LABEL_W),
    .LAT_OP0(MUL_LAT), .LAT_OP1(DIV_LAT), .IS_MULDIV(1'b1)
  ) u_muldiv (
    .i_clk(Clock), .i_rst(Reset), .i_run(Run_MulDiv),
    .i_rx(Rx_MulDiv), .i_ry(Ry_MulDiv), .i_op_sel(Op_MulDiv[0]),
    .i_label(Label_MulDiv), .o_result(Result_MulDiv), .o_done(Done_MulDiv),
    .o_label(Label_MulDiv_out), .o_state(Dbg_State_MulDiv)
  );

  // CDB select; unused codes drive zero so the bus is never undefined
  always_comb begin
    CDB = '0;
    case (CDB_Control)
      2'b01:   CDB = Result_AddSub;
      2'b10:   CDB = Result_MulDiv;
      default: CDB = '0;
    endcase
  end

endmodule

// File: tb/tb_tomasulo_exec_units.sv
// Bench for tomasulo_exec_units: directed cases followed by random ops,
// each compared against an arithmetic reference model.

module tb_tomasulo_exec_units;

  localparam int W  = 12;
  localparam int LW = 2;

  logic          Clock = 1'b0;
  logic          Reset;
  logic          Run_AddSub = 1'b0;
  logic [W-1:0]  Rx_AddSub = '0, Ry_AddSub = '0;
  logic [2:0]    Op_AddSub = '0;
  logic [LW-1:0] Label_AddSub = '0;
  logic [W-1:0]  Result_AddSub;
  logic          Done_AddSub;
  logic [LW-1:0] Label_AddSub_out;
  logic          Run_MulDiv = 1'b0;
  logic [W-1:0]  Rx_MulDiv = '0, Ry_MulDiv = '0;
  logic [2:0]    Op_MulDiv = '0;
  logic [LW-1:0] Label_MulDiv = '0;
  logic [W-1:0]  Result_MulDiv;
  logic          Done_MulDiv;
  logic [LW-1:0] Label_MulDiv_out;
  logic [1:0]    CDB_Control = 2'b00;
  logic [W-1:0]  CDB;
  logic [1:0]    Dbg_State_AddSub, Dbg_State_MulDiv;

  tomasulo_exec_units dut (
    .Clock(Clock), .Reset(Reset),
    .Run_AddSub(Run_AddSub), .Rx_AddSub(Rx_AddSub), .Ry_AddSub(Ry_AddSub),
    .Op_AddSub(Op_AddSub), .Label_AddSub(Label_AddSub),
    .Result_AddSub(Result_AddSub), .Done_AddSub(Done_AddSub),
    .Label_AddSub_out(Label_AddSub_out),
    .Run_MulDiv(Run_MulDiv), .Rx_MulDiv(Rx_MulDiv), .Ry_MulDiv(Ry_MulDiv),
    .Op_MulDiv(Op_MulDiv), .Label_MulDiv(Label_MulDiv),
    .Result_MulDiv(Result_MulDiv), .Done_MulDiv(Done_MulDiv),
    .Label_MulDiv_out(Label_MulDiv_out),
    .CDB_Control(CDB_Control), .CDB(CDB),
    .Dbg_State_AddSub(Dbg_State_AddSub), .Dbg_State_MulDiv(Dbg_State_MulDiv)
  );

  // ---------------- clock / reset ----------------
  always #5 Clock = ~Clock;

  initial begin
    Reset = 1'b1;
    #200000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  int           n_checks = 0;
  int           n_errors = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] last_res[2];   // expected held result of each FU

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [W-1:0] model(input int fu, input logic [2:0] op,
                                         input int unsigned rx, input int unsigned ry);
    int unsigned r;
    if (fu == 0) r = op[0] ? (rx + 4096 - ry) % 4096 : (rx + ry) % 4096;
    else if (!op[0]) r = (rx * ry) % 4096;
    else if (ry == 0) r = 4095;
    else r = rx / ry;
    return r[W-1:0];
  endfunction

  function automatic int lat_of(input int fu, input logic [2:0] op);
    if (fu == 0) return 2;
    return op[0] ? 6 : 4;
  endfunction

  function automatic logic [W-1:0] exp_cdb(input logic [1:0] sel);
    if (sel == 2'b01) return last_res[0];
    if (sel == 2'b10) return last_res[1];
    return '0;
  endfunction

  function automatic logic get_done(input int fu);
    return (fu == 0) ? Done_AddSub : Done_MulDiv;
  endfunction

  function automatic logic [W-1:0] get_result(input int fu);
    return (fu == 0) ? Result_AddSub : Result_MulDiv;
  endfunction

  function automatic logic [LW-1:0] get_label(input int fu);
    return (fu == 0) ? Label_AddSub_out : Label_MulDiv_out;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive(input int fu, input logic [W-1:0] rx, input logic [W-1:0] ry,
                       input logic [2:0] op, input logic [LW-1:0] lb);
    if (fu == 0) begin
      Rx_AddSub = rx; Ry_AddSub = ry; Op_AddSub = op; Label_AddSub = lb; Run_AddSub = 1'b1;
    end else begin
      Rx_MulDiv = rx; Ry_MulDiv = ry; Op_MulDiv = op; Label_MulDiv = lb; Run_MulDiv = 1'b1;
    end
  endtask

  task automatic set_run(input int fu, input logic v);
    if (fu == 0) Run_AddSub = v;
    else         Run_MulDiv = v;
  endtask

  task automatic scramble(input int fu);
    if (fu == 0) begin
      Rx_AddSub = W'($urandom); Ry_AddSub = W'($urandom);
      Op_AddSub = 3'($urandom); Label_AddSub = LW'($urandom);
    end else begin
      Rx_MulDiv = W'($urandom); Ry_MulDiv = W'($urandom);
      Op_MulDiv = 3'($urandom); Label_MulDiv = LW'($urandom);
    end
  endtask

  task automatic check_cdb(input logic [1:0] sel, input string tag);
    CDB_Control = sel;
    #1;
    check(tag, CDB, exp_cdb(sel));
  endtask

  // Issue one op, wait (bounded) for Done, check latency, result, label and CDB.
  task automatic issue(input int fu, input logic [W-1:0] rx, input logic [W-1:0] ry,
                       input logic [2:0] op, input logic [LW-1:0] lb,
                       input bit scr, input string tag);
    logic [W-1:0] exp_v;
    int lat, k;
    bit seen;
    @(negedge Clock);
    drive(fu, rx, ry, op, lb);
    exp_v = model(fu, op, rx, ry);
    exp_q.push_back(exp_v);
    lat = lat_of(fu, op);
    @(posedge Clock); #1;
    check({tag, "_acc_done"}, get_done(fu), 1'b0);
    if (scr) scramble(fu);
    seen = 0;
    k = 0;
    while (!seen && k < 30) begin
      @(posedge Clock); #1;
      k++;
      if (get_done(fu)) seen = 1;
      else if (scr) scramble(fu);
    end
    check({tag, "_lat"}, k, lat);
    check({tag, "_res"}, get_result(fu), exp_q.pop_front());
    check({tag, "_lbl"}, get_label(fu), lb);
    last_res[fu] = exp_v;
    check_cdb(2'($urandom), {tag, "_cdb"});
  endtask

  // Drop Run of a Done FU: Done must clear next edge, result held.
  task automatic release_fu(input int fu, input string tag);
    @(negedge Clock);
    set_run(fu, 1'b0);
    @(posedge Clock); #1;
    check({tag, "_rel_done"}, get_done(fu), 1'b0);
    check({tag, "_rel_res"}, get_result(fu), last_res[fu]);
  endtask

  task automatic apply_reset();
    @(negedge Clock);
    Reset = 1'b1;
    Run_AddSub = 1'b0;
    Run_MulDiv = 1'b0;
    repeat (2) @(posedge Clock);
    #1;
    last_res[0] = '0;
    last_res[1] = '0;
    @(negedge Clock);
    Reset = 1'b0;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [2:0] op;
    logic [W-1:0] ry;
    int fu;

    last_res[0] = '0;
    last_res[1] = '0;
    apply_reset();

    // reset state
    check("rst_done_as", Done_AddSub, 1'b0);
    check("rst_res_as", Result_AddSub, 0);
    check("rst_lbl_as", Label_AddSub_out, 0);
    check("rst_done_md", Done_MulDiv, 1'b0);
    check("rst_res_md", Result_MulDiv, 0);
    check("rst_lbl_md", Label_MulDiv_out, 0);
    for (int s = 0; s < 4; s++) check_cdb(2'(s), "rst_cdb");

    // directed arithmetic
    issue(0, 12'd5, 12'd7, 3'b000, 2'd1, 0, "add_5_7");
    release_fu(0, "add_5_7");
    issue(0, 12'd3, 12'd5, 3'b001, 2'd2, 0, "sub_3_5");
    release_fu(0, "sub_3_5");
    issue(0, 12'hFFF, 12'd1, 3'b000, 2'd3, 0, "add_wrap");
    release_fu(0, "add_wrap");
    issue(1, 12'd100, 12'd50, 3'b010, 2'd2, 0, "mul_100_50");
    release_fu(1, "mul_100_50");
    issue(1, 12'd100, 12'd7, 3'b011, 2'd3, 0, "div_100_7");
    release_fu(1, "div_100_7");
    issue(1, 12'd9, 12'd0, 3'b011, 2'd0, 0, "div_by_zero");
    release_fu(1, "div_by_zero");

    // both FUs done together, CDB selects
    @(negedge Clock);
    drive(0, 12'd1000, 12'd24, 3'b000, 2'd1);
    drive(1, 12'd3, 12'd5, 3'b010, 2'd2);
    @(posedge Clock);
    repeat (4) @(posedge Clock);
    #1;
    last_res[0] = model(0, 3'b000, 1000, 24);
    last_res[1] = model(1, 3'b010, 3, 5);
    check("both_done_as", Done_AddSub, 1'b1);
    check("both_done_md", Done_MulDiv, 1'b1);
    check("both_res_as", Result_AddSub, last_res[0]);
    check("both_res_md", Result_MulDiv, last_res[1]);
    for (int s = 0; s < 4; s++) check_cdb(2'(s), "both_cdb");
    release_fu(0, "both_as");
    check("both_md_held", Done_MulDiv, 1'b1);
    release_fu(1, "both_md");

    // inputs changing while busy must not affect the result
    issue(0, 12'd1234, 12'd234, 3'b001, 2'd3, 1, "scr_sub");
    release_fu(0, "scr_sub");
    issue(1, 12'd4000, 12'd13, 3'b011, 2'd1, 1, "scr_div");
    release_fu(1, "scr_div");

    // abort mid-BUSY: Done never rises, then a fresh op completes
    @(negedge Clock);
    drive(1, 12'd200, 12'd3, 3'b011, 2'd2);
    repeat (3) @(posedge Clock);
    @(negedge Clock);
    set_run(1, 1'b0);
    for (int i = 0; i < 8; i++) begin
      @(posedge Clock); #1;
      check("abort_no_done", Done_MulDiv, 1'b0);
    end
    check("abort_res_held", Result_MulDiv, last_res[1]);
    issue(1, 12'd21, 12'd2, 3'b010, 2'd1, 0, "after_abort");
    release_fu(1, "after_abort");

    // reset during DIV
    @(negedge Clock);
    drive(1, 12'd500, 12'd5, 3'b011, 2'd3);
    repeat (3) @(posedge Clock);
    @(negedge Clock);
    Reset = 1'b1;
    set_run(1, 1'b0);
    @(posedge Clock); #1;
    last_res[0] = '0;
    last_res[1] = '0;
    check("rstdiv_done", Done_MulDiv, 1'b0);
    check("rstdiv_res", Result_MulDiv, 0);
    check("rstdiv_lbl", Label_MulDiv_out, 0);
    check("rstdiv_res_as", Result_AddSub, 0);
    @(negedge Clock);
    Reset = 1'b0;
    issue(1, 12'd77, 12'd7, 3'b011, 2'd2, 0, "after_rst");
    release_fu(1, "after_rst");

    // random ops
    for (int n = 0; n < 40; n++) begin
      fu = int'($urandom_range(0, 1));
      op = 3'($urandom);
      ry = ($urandom_range(0, 5) == 0) ? '0 : W'($urandom);
      issue(fu, W'($urandom), ry, op, LW'($urandom), bit'($urandom_range(0, 1)), "rnd");
      release_fu(fu, "rnd");
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/tomasulo_exec_units.md
Name: tomasulo_exec_units

Overview:
- Execution back end of the Tomasulo reservation-station controller.
- Contains two functional units and the Common Data Bus (CDB) mux:
  - add/sub FU, 2 ops
  - mul/div FU, 2 ops
  - combinational CDB arbiter mux
- Each FU takes operands, an opcode and a reservation-station label, computes after a fixed latency, then holds result, label and Done until the controller releases it. The controller picks which result drives the CDB.

Parameters:
- WIDTH, 12, data width of operands, results and CDB.
- LABEL_W, 2, reservation-station label width.
- ADDSUB_LAT, 2, cycles from accepted Run to Done for ADD/SUB (min 1).
- MUL_LAT, 4, cycles from accepted Run to Done for MUL (min 1).
- DIV_LAT, 6, cycles from accepted Run to Done for DIV (min 1).

Ports:
- Clock  in  1  rising-edge clock
- Reset  in  1  synchronous, active-high reset
- Run_AddSub  in  1  level request to add/sub FU
- Rx_AddSub, Ry_AddSub  in  WIDTH  operands
- Op_AddSub  in  3  000 ADD, 001 SUB
- Label_AddSub  in  LABEL_W  issuing RS label
- Result_AddSub  out  WIDTH  registered result
- Done_AddSub  out  1  result valid
- Label_AddSub_out  out  LABEL_W  label of the completed op
- Run_MulDiv, Rx_MulDiv, Ry_MulDiv, Op_MulDiv (010 MUL, 011 DIV), Label_MulDiv  in  same widths as add/sub
- Result_MulDiv, Done_MulDiv, Label_MulDiv_out  out  same widths as add/sub
- CDB_Control  in  2  bus select
- CDB  out  WIDTH  common data bus

Behaviour:
- Clock and reset: single clock domain; reset is synchronous and active-high, sampled on rising Clock.
- Reset state (both FUs): IDLE, Done=0, Result=0, Label_out=0. Reset aborts any in-flight op.
- FU state machine: IDLE -> BUSY -> DONE.
  - IDLE: on edge with Run=1, latch Rx, Ry, Op, Label; load counter with op latency; go BUSY.
  - BUSY: counter decrements each edge. When it expires, register the result and Label_out, set Done=1, go DONE.
  - Latency: Done first high exactly LAT edges after the accepting edge.
  - Operand, op and label inputs are ignored while BUSY or DONE; latched copies are used.
  - BUSY with Run=0 sampled: abort and return to IDLE; Done stays 0.
  - DONE: Done, Result and Label_out held stable while Run=1. First edge with Run=0 clears Done (Result and Label_out retain value) and returns to IDLE. A new op is not accepted in that same edge; the next accept is at the earliest one edge later.
- Opcode decode: Op[0] selects the operation inside each FU; Op[2:1] is ignored.
  - Add/sub FU: ADD = (Rx+Ry) mod 2^WIDTH; SUB = (Rx-Ry) mod 2^WIDTH (two's-complement wrap).
  - Mul/div FU: MUL = low WIDTH bits of unsigned Rx*Ry; DIV = unsigned floor(Rx/Ry).
  - Divide by zero yields all-ones (12'hFFF) after DIV_LAT with no other flag.
- Both FUs are independent and may be Done simultaneously; the arbiter does not arbitrate itself, the controller drives CDB_Control.
- CDB (purely combinational, no clock or reset):
  - 01 -> Result_AddSub
  - 10 -> Result_MulDiv
  - 00 or 11 -> 0
- No X propagation: all registers reset; CDB is always defined.

Test Plan:
- Reset, then ADD 5+7 with Label 1 -> Done_AddSub rises 2 edges after accept; Result_AddSub=12; Label_AddSub_out=1. Drop Run -> Done falls next edge.
- SUB 3-5 -> Result_AddSub=12'hFFE. ADD 12'hFFF+1 -> Result_AddSub=0 (wrap).
- MUL 100*50 with Label 2 -> Done after 4 edges; Result=5000 mod 4096=904. DIV 100/7 with Label 3 -> Done after 6 edges; Result=14, Label_out=3. DIV 9/0 -> 12'hFFF.
- Both FUs issued so Done coincides; CDB_Control 01 -> CDB=AddSub result; 10 -> MulDiv result; 00 and 11 -> CDB=0. Each FU holds Done until its own Run drops.
- Change Rx/Ry/Op/Label while BUSY -> result uses the originally latched values. Drop Run mid-BUSY -> no Done; FU accepts a new op afterwards.
- Assert Reset during a DIV -> next edge Done=0, Result=0, Label_out=0; FU idle. A new Run is accepted after Reset deasserts.
